// File: rtl/tremolo_modulator.sv
// Tremolo amplitude modulator: phase-accumulator-driven LFO scales the codec sample stream
// with a fixed 2-cycle latency. Define TREMOLO_SINE_EN for a sine LFO instead of the triangle.
module tremolo_modulator #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 192
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [31:0]       frequency,
  input  logic              disabled,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_sample,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_sample,
  output logic [7:0]        lfo_level
);

  localparam logic [8:0] DEPTH_C = 9'(DEPTH);

  logic [31:0]       acc_q, acc_d;
  logic [32:0]       acc_sum_s;
  logic              lfo_step_s;
  logic [7:0]        lfo_q, lfo_d;
  logic [16:0]       scaled_s;
  logic [8:0]        gain_s;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [8:0]        gain_q, gain_d;
  logic              bypass_q, bypass_d;
  logic              v1_q, v1_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_sample_q, out_sample_d;
  logic signed [DATA_W+9:0] prod_s;

  // Carry out of the phase accumulator is one LFO step.
  assign acc_sum_s  = {1'b0, acc_q} + {1'b0, frequency};
  assign lfo_step_s = acc_sum_s[32] & ~disabled;
  assign acc_d      = disabled ? 32'd0 : acc_sum_s[31:0];

`ifdef TREMOLO_SINE_EN
  localparam logic [6:0] SINE_Q [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic [7:0] idx_q, idx_d;

  // Quadrants are arranged so index 0 sits at the minimum (level 0, unity gain).
  function automatic logic [7:0] sine_level(input logic [7:0] idx);
    logic [7:0] fwd;
    logic [7:0] rev;
    fwd = {1'b0, SINE_Q[idx[5:0]]};
    rev = {1'b0, SINE_Q[~idx[5:0]]};
    case (idx[7:6])
      2'd0:    sine_level = 8'd127 - rev;
      2'd1:    sine_level = 8'd128 + fwd;
      2'd2:    sine_level = 8'd128 + rev;
      default: sine_level = 8'd127 - fwd;
    endcase
  endfunction

  always_comb begin
    idx_d = idx_q;
    lfo_d = 8'd0;
    if (disabled) begin
      idx_d = 8'd0;
      lfo_d = 8'd0;
    end else begin
      idx_d = idx_q + {7'd0, lfo_step_s};
      lfo_d = sine_level(idx_q);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx_q <= 8'd0;
    end else begin
      idx_q <= idx_d;
    end
  end
`else
  logic dir_down_q, dir_down_d;

  // Triangle: direction flips on the step that lands on 255 or on 0.
  always_comb begin
    lfo_d      = lfo_q;
    dir_down_d = dir_down_q;
    if (disabled) begin
      lfo_d      = 8'd0;
      dir_down_d = 1'b0;
    end else if (lfo_step_s) begin
      if (!dir_down_q) begin
        lfo_d      = lfo_q + 8'd1;
        dir_down_d = (lfo_q == 8'd254);
      end else begin
        lfo_d      = lfo_q - 8'd1;
        dir_down_d = (lfo_q != 8'd1);
      end
    end else begin
      lfo_d      = lfo_q;
      dir_down_d = dir_down_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dir_down_q <= 1'b0;
    end else begin
      dir_down_q <= dir_down_d;
    end
  end
`endif

  assign scaled_s = {9'd0, lfo_q} * {8'd0, DEPTH_C};
  assign gain_s   = 9'd256 - 9'(scaled_s >> 8);
  assign prod_s   = $signed(sample_q) * $signed({1'b0, gain_q});

  // Stage 1 captures on in_valid; stage 2 holds its sample while idle.
  always_comb begin
    sample_d     = sample_q;
    gain_d       = gain_q;
    bypass_d     = bypass_q;
    v1_d         = in_valid;
    out_valid_d  = v1_q;
    out_sample_d = out_sample_q;
    if (in_valid) begin
      sample_d = in_sample;
      gain_d   = gain_s;
      bypass_d = disabled;
    end else begin
      sample_d = sample_q;
    end
    if (v1_q) begin
      out_sample_d = bypass_q ? sample_q : DATA_W'(prod_s >>> 8);
    end else begin
      out_sample_d = out_sample_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q        <= 32'd0;
      lfo_q        <= 8'd0;
      sample_q     <= '0;
      gain_q       <= 9'd256;
      bypass_q     <= 1'b0;
      v1_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
    end else begin
      acc_q        <= acc_d;
      lfo_q        <= lfo_d;
      sample_q     <= sample_d;
      gain_q       <= gain_d;
      bypass_q     <= bypass_d;
      v1_q         <= v1_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign lfo_level  = lfo_q;

endmodule

// File: tb/tb_tremolo_modulator.sv
// Self-checking bench for tremolo_modulator (triangle build): fixed vectors, hand sequences
// and randomized traffic against a step-count based reference model.
module tb_tremolo_modulator;

  localparam int DW    = 16;
  localparam int DEPTH = 192;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic [31:0]   frequency;
  logic          disabled;
  logic          in_valid;
  logic [DW-1:0] in_sample;
  logic          out_valid;
  logic [DW-1:0] out_sample;
  logic [7:0]    lfo_level;

  tremolo_modulator #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .frequency(frequency), .disabled(disabled),
    .in_valid(in_valid), .in_sample(in_sample), .out_valid(out_valid),
    .out_sample(out_sample), .lfo_level(lfo_level)
  );

  always #10 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: LFO level derived from total steps since reset/disable.
  longint unsigned m_acc   = 0;
  int              m_steps = 0;
  logic            m_v1    = 1'b0;
  logic [DW-1:0]   m_s1    = '0;
  logic            m_ov    = 1'b0;
  logic [DW-1:0]   m_os    = '0;

  typedef struct {
    int          lvl;
    logic        dis;
    logic [15:0] smp;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[9];

  function automatic int tri_level(input int steps);
    int k;
    k = steps % 510;
    return (k <= 255) ? k : 510 - k;
  endfunction

  function automatic logic [DW-1:0] expect_out(input logic [DW-1:0] s, input int lvl, input logic dis);
    int gain;
    int p;
    if (dis) return s;
    gain = 256 - (lvl * DEPTH) / 256;
    p = int'($signed(s)) * gain;
    return DW'(p >>> 8);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_steps = 0; m_v1 = 1'b0; m_s1 = '0; m_ov = 1'b0; m_os = '0;
  endtask

  task automatic tick();
    longint unsigned sum;
    logic            n_ov;
    logic [DW-1:0]   n_os;
    n_ov = m_v1;
    n_os = m_v1 ? m_s1 : m_os;
    if (in_valid) m_s1 = expect_out(in_sample, tri_level(m_steps), disabled);
    m_v1 = in_valid;
    m_ov = n_ov;
    m_os = n_os;
    if (disabled) begin
      m_acc = 0;
      m_steps = 0;
    end else begin
      sum = m_acc + 64'(frequency);
      if (sum >= 64'h1_0000_0000) m_steps++;
      m_acc = sum & 64'hFFFF_FFFF;
    end
    @(posedge CLK);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_sample", {16'd0, out_sample}, {16'd0, m_os});
    chk("lfo_level", {24'd0, lfo_level}, 32'(tri_level(m_steps)));
  endtask

  task automatic seek(input int target);
    int guard;
    disabled = 1'b1; frequency = 32'd0; in_valid = 1'b0;
    tick();
    disabled = 1'b0; frequency = 32'hFFFF_FFFF;
    guard = 0;
    while (tri_level(m_steps) != target && guard < 600) begin
      tick();
      guard++;
    end
    frequency = 32'd0;
    chk("seek_level", {24'd0, lfo_level}, 32'(target));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    vecs[0] = '{0,   1'b0, 16'h4000, 16'h4000};
    vecs[1] = '{255, 1'b0, 16'h4000, 16'h1040};
    vecs[2] = '{255, 1'b0, 16'h8000, 16'hDF80};
    vecs[3] = '{255, 1'b0, 16'h7FFF, 16'h207F};
    vecs[4] = '{255, 1'b0, 16'hFFFF, 16'hFFFF};
    vecs[5] = '{128, 1'b0, 16'h4000, 16'h2800};
    vecs[6] = '{128, 1'b0, 16'hC000, 16'hD800};
    vecs[7] = '{128, 1'b1, 16'h1234, 16'h1234};
    vecs[8] = '{0,   1'b0, 16'h8000, 16'h8000};

    RST_N = 1'b0; frequency = 32'd0; disabled = 1'b0; in_valid = 1'b0; in_sample = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_sample", {16'd0, out_sample}, 32'd0);
    chk("rst_lfo", {24'd0, lfo_level}, 32'd0);
    @(negedge CLK) RST_N = 1'b1;

    for (int i = 0; i < 9; i++) begin
      seek(vecs[i].lvl);
      in_valid = 1'b1; in_sample = vecs[i].smp; disabled = vecs[i].dis;
      tick();
      if (vecs[i].dis) chk("dis_lfo_zero", {24'd0, lfo_level}, 32'd0);
      in_valid = 1'b0; disabled = 1'b0;
      tick();
      chk("vec_valid", {31'd0, out_valid}, 32'd1);
      chk("vec_out", {16'd0, out_sample}, {16'd0, vecs[i].exp});
    end

    disabled = 1'b1; frequency = 32'd0;
    tick();
    disabled = 1'b0; frequency = 32'h8000_0000;
    repeat (510) tick();
    chk("tri_peak", {24'd0, lfo_level}, 32'd255);
    repeat (2) tick();
    chk("tri_254", {24'd0, lfo_level}, 32'd254);
    repeat (508) tick();
    chk("tri_zero", {24'd0, lfo_level}, 32'd0);
    repeat (2) tick();
    chk("tri_rise", {24'd0, lfo_level}, 32'd1);

    seek(77);
    repeat (10000) tick();
    chk("freeze", {24'd0, lfo_level}, 32'd77);
    cnt = 0;
    for (int i = 0; i < 102; i++) begin
      in_valid = (i < 100);
      in_sample = DW'($urandom);
      tick();
      cnt += int'(out_valid);
    end
    chk("burst_count", 32'(cnt), 32'd100);

    seek(200);
    in_valid = 1'b1; in_sample = 16'h5A5A;
    tick();
    in_sample = 16'h3C3C;
    tick();
    #4 RST_N = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_sample", {16'd0, out_sample}, 32'd0);
    chk("async_rst_lfo", {24'd0, lfo_level}, 32'd0);
    model_reset();
    in_valid = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt += int'(out_valid);
    end
    chk("no_stale_valid", 32'(cnt), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) begin
        case ((i / 500) % 3)
          0:       frequency = 32'hFFFF_FFFF;
          1:       frequency = $urandom;
          default: frequency = $urandom_range(32'h4000_0000, 32'hC000_0000);
        endcase
      end
      disabled  = ($urandom_range(0, 127) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      in_sample = DW'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
